// File: rtl/ws2812b_pkg.sv
// Shared definitions for the WS2812B chain controller: FSM encoding, colour
// word layout and the default latch gap at 50 MHz.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  localparam int COLOR_W = 24;
  localparam int R_MSB   = 23;
  localparam int R_LSB   = 16;
  localparam int G_MSB   = 15;
  localparam int G_LSB   = 8;
  localparam int B_MSB   = 7;
  localparam int B_LSB   = 0;

  // 300 us of idle line at 50 MHz latches the pixels.
  localparam int LATCH_CYCLES_50MHZ = 15000;

endpackage

// File: rtl/ws2812b_pixel_ram.sv
// Pixel buffer: register file with synchronous clear, one synchronous write
// port and one combinational read port (read returns the pre-write value).
module ws2812b_pixel_ram
  import ws2812b_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [COLOR_W-1:0] rd_data
);

  // Depth is rounded up to the address space; entries at or above NUM_LEDS
  // are never written, stay zero and fold away.
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_LEDS);

  logic [COLOR_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && ({1'b0, wr_addr} < LIMIT)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ws2812b_chain_ctrl.sv
// Frame sequencer for a chain of WS2812B pixels: feeds one colour per pixel to
// the serial driver, then holds the line idle for the latch gap.
module ws2812b_chain_ctrl
  import ws2812b_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int ADDR_W       = 3,
  parameter int LATCH_CYCLES = LATCH_CYCLES_50MHZ,
  parameter int LATCH_W      = 14
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  input  logic               start,
  output logic               busy,
  output logic               frame_done,
  output logic               drv_enable,
  output logic [7:0]         drv_r,
  output logic [7:0]         drv_g,
  output logic [7:0]         drv_b,
  input  logic               drv_ready,
  output state_t             state
);

  localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(NUM_LEDS - 1);
  localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(LATCH_CYCLES - 1);

  logic [ADDR_W-1:0]  index;
  logic [LATCH_W-1:0] latch_cnt;
  logic [COLOR_W-1:0] pixel;

  ws2812b_pixel_ram #(
    .NUM_LEDS(NUM_LEDS),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(index),
    .rd_data(pixel)
  );

  // Driver handshake: drv_enable stays high for the whole pixel stream and the
  // colour on drv_r/g/b is valid while it is high; drv_ready is a one-cycle
  // pulse meaning the current word has shifted out, honoured only in SEND.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      drv_enable <= 1'b0;
      drv_r      <= '0;
      drv_g      <= '0;
      drv_b      <= '0;
      index      <= '0;
      latch_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
            index <= '0;
          end
        end
        ST_LOAD: begin
          drv_r      <= pixel[R_MSB:R_LSB];
          drv_g      <= pixel[G_MSB:G_LSB];
          drv_b      <= pixel[B_MSB:B_LSB];
          drv_enable <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND: begin
          if (drv_ready) begin
            if (index == LAST_IDX) begin
              drv_enable <= 1'b0;
              latch_cnt  <= '0;
              state      <= ST_LATCH;
            end else begin
              index <= index + 1'b1;
              state <= ST_LOAD;
            end
          end
        end
        ST_LATCH: begin
          if (latch_cnt == LATCH_LAST) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            latch_cnt <= latch_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
